// File: rtl/shared_adder_pkg.sv
// shared_adder_pkg: shared width, requester ids and output-register states for shared_adder_arb
package shared_adder_pkg;
  localparam int DATA_W = 32;
  typedef enum logic {REQ_MUL = 1'b0, REQ_DIV = 1'b1} req_id_t;
  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;
endpackage

// File: rtl/shared_adder_arb_cla.sv
// cla_add32: 32-bit carry-lookahead adder, 4-bit lookahead groups with group-level carry chain
module cla_add32
  import shared_adder_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              Cin,
  output logic [DATA_W-1:0] s,
  output logic              overflow
);
  logic [DATA_W-1:0] g, p;
  logic [DATA_W:0]   c;
  logic [7:0]        gg, gp;
  logic [8:0]        gc;
  assign g = a & b;
  assign p = a ^ b;
  // group generate/propagate, group carries, then in-group lookahead carries
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c = '0;
    gc[0] = Cin;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+2 +: 2] & g[4*k+1]) | (&p[4*k+1 +: 3] & g[4*k]);
      gp[k] = &p[4*k +: 4];
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
      c[4*k] = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (&p[4*k +: 2] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (&p[4*k+1 +: 2] & g[4*k]) | (&p[4*k +: 3] & gc[k]);
    end
    c[DATA_W] = gc[8];
  end
  assign s = p ^ c[DATA_W-1:0];
  assign overflow = c[DATA_W-1] ^ c[DATA_W];
endmodule

// File: rtl/shared_adder_arb_rr_arb2.sv
// rr_arb2: 2-way round-robin grant with last_gnt pointer; optional grant lock under SHARED_ADDER_LOCK_EN
module rr_arb2
  import shared_adder_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  input  logic       eligible,
  output logic [1:0] grant
);
  req_id_t    last_gnt_q, last_gnt_d;
  logic [1:0] rr;
  logic       accept;
  assign rr = &valid ? (last_gnt_q == REQ_DIV ? 2'b01 : 2'b10) : valid;
  assign accept = eligible & |grant;
  assign last_gnt_d = accept ? req_id_t'(grant[1]) : last_gnt_q;
`ifdef SHARED_ADDER_LOCK_EN
  logic    lock_act_q, lock_act_d;
  req_id_t lock_own_q, lock_own_d;
  assign grant = lock_act_q ? (lock_own_q == REQ_DIV ? {valid[1], 1'b0} : {1'b0, valid[0]}) : rr;
  assign lock_act_d = accept ? lock[grant[1]] : lock_act_q;
  assign lock_own_d = accept ? req_id_t'(grant[1]) : lock_own_q;
  // lock holder and active flag, cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_act_q <= 1'b0;
      lock_own_q <= REQ_MUL;
    end else begin
      lock_act_q <= lock_act_d;
      lock_own_q <= lock_own_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign grant = rr;
`endif
  // round-robin pointer advances only on an accepted transfer
  always_ff @(posedge clock) begin
    if (reset) last_gnt_q <= REQ_DIV;
    else last_gnt_q <= last_gnt_d;
  end
endmodule

// File: rtl/shared_adder_arb.sv
// shared_adder_arb: time-shares one 32-bit CLA between multiplier and divider with a one-entry result register (SHARED_ADDER_LOCK_EN enables grant lock)
module shared_adder_arb
  import shared_adder_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [1:0]        req_sub,
  input  logic [1:0]        req_lock,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ovf
);
  out_state_t        state_q, state_d;
  req_id_t           owner_q, owner_d;
  logic [DATA_W-1:0] data_q, data_d, op_a, op_b, sum;
  logic              ovf_q, ovf_d, op_sub, sum_ovf, consume, eligible, accept;
  logic [1:0]        grant;
  assign consume = (state_q == OUT_FULL) & rsp_ready[owner_q];
  assign eligible = (state_q == OUT_EMPTY) | consume;
  assign req_ready = (eligible & ~reset) ? grant : 2'b00;
  assign accept = |req_ready;
  rr_arb2 arb (
    .clock    (clock),
    .reset    (reset),
    .valid    (req_valid),
    .lock     (req_lock),
    .eligible (eligible),
    .grant    (grant)
  );
  // operand mux for the granted requester; subtract as a + ~b + 1
  always_comb begin
    op_sub = grant[1] ? req_sub[1] : req_sub[0];
    op_a = grant[1] ? req_a1 : req_a0;
    op_b = (grant[1] ? req_b1 : req_b0) ^ {DATA_W{op_sub}};
  end
  cla_add32 cla_add (
    .overflow (sum_ovf),
    .s        (sum),
    .a        (op_a),
    .b        (op_b),
    .Cin      (op_sub)
  );
  // next state of the result register: accept wins over consume for pass-through
  always_comb begin
    state_d = accept ? OUT_FULL : (consume ? OUT_EMPTY : state_q);
    owner_d = accept ? req_id_t'(grant[1]) : owner_q;
    data_d = accept ? sum : data_q;
    ovf_d = accept ? sum_ovf : ovf_q;
  end
  // result register; reset discards any pending result
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OUT_EMPTY;
      owner_q <= REQ_MUL;
      data_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      data_q <= data_d;
      ovf_q <= ovf_d;
    end
  end
  assign rsp_valid = (state_q == OUT_FULL) ? (owner_q == REQ_DIV ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data = data_q;
  assign rsp_ovf = ovf_q;
endmodule

// File: tb/tb_shared_adder_arb.sv
// tb_shared_adder_arb: directed-vector bench for shared_adder_arb (lock steps need SHARED_ADDER_LOCK_EN)
module tb_shared_adder_arb;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_sub, req_lock, rsp_valid, rsp_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1, rsp_data;
  logic        rsp_ovf;
  int          vectors = 0;
  int          miscompares = 0;

  shared_adder_arb dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_sub   (req_sub),
    .req_lock  (req_lock),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b01;
    req_sub = 2'b00;
    req_lock = 2'b00;
    rsp_ready = 2'b11;
    req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
    tick();
    tick();
    chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_ovf", {31'd0, rsp_ovf}, 32'd0);
    // single requester: 5 + 7
    reset = 1'b0;
    req_valid = 2'b01; req_a0 = 32'd5; req_b0 = 32'd7;
    #1;
    chk("add_ready", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    #1;
    chk("add_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("add_data", rsp_data, 32'd12);
    chk("add_ovf", {31'd0, rsp_ovf}, 32'd0);
    tick();
    chk("add_consumed", {30'd0, rsp_valid}, 32'd0);
    // fresh pointer, then both requesters contend for 4 cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 2'b11;
    req_a0 = 32'd1; req_b0 = 32'd1; req_a1 = 32'd10; req_b1 = 32'd3; req_sub = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk("rr_rsp_valid", {30'd0, rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_data", rsp_data, (i % 2 == 0) ? 32'd2 : 32'd7);
    end
    req_valid = 2'b00; req_sub = 2'b00;
    tick();
    // overflow corners on requester 0
    req_valid = 2'b01; req_a0 = 32'h7FFF_FFFF; req_b0 = 32'd1; req_sub = 2'b00;
    tick();
    req_valid = 2'b00;
    chk("ovf_add_data", rsp_data, 32'h8000_0000);
    chk("ovf_add_ovf", {31'd0, rsp_ovf}, 32'd1);
    req_valid = 2'b01; req_a0 = 32'h8000_0000; req_b0 = 32'd1; req_sub = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("ovf_sub_data", rsp_data, 32'h7FFF_FFFF);
    chk("ovf_sub_ovf", {31'd0, rsp_ovf}, 32'd1);
    req_valid = 2'b01; req_a0 = 32'd3; req_b0 = 32'd5; req_sub = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("neg_sub_data", rsp_data, 32'hFFFF_FFFE);
    chk("neg_sub_ovf", {31'd0, rsp_ovf}, 32'd0);
    tick();
    chk("neg_sub_consumed", {30'd0, rsp_valid}, 32'd0);
    // backpressure: owner 0 stalls with both requesters waiting
    req_sub = 2'b00; rsp_ready = 2'b00;
    req_valid = 2'b01; req_a0 = 32'd100; req_b0 = 32'd1;
    tick();
    req_valid = 2'b11; req_a0 = 32'd200; req_b0 = 32'd0; req_a1 = 32'd50; req_b1 = 32'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", {30'd0, req_ready}, 32'd0);
      chk("bp_data", rsp_data, 32'd101);
      chk("bp_valid", {30'd0, rsp_valid}, 32'd1);
      tick();
    end
    rsp_ready = 2'b01;
    #1;
    chk("bp_release_grant", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b00;
    chk("bp_next_valid", {30'd0, rsp_valid}, 32'd2);
    chk("bp_next_data", rsp_data, 32'd55);
    tick();
    chk("non_owner_ready_ignored", {30'd0, rsp_valid}, 32'd2);
    rsp_ready = 2'b11;
    tick();
    chk("bp_drained", {30'd0, rsp_valid}, 32'd0);
    // reset while FULL after a requester-0 grant
    rsp_ready = 2'b00;
    req_valid = 2'b01; req_a0 = 32'd9; req_b0 = 32'd9;
    tick();
    req_valid = 2'b00;
    chk("pre_reset_full", {30'd0, rsp_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("post_reset_valid", {30'd0, rsp_valid}, 32'd0);
    chk("post_reset_data", rsp_data, 32'd0);
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    chk("post_reset_grant", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    tick();
`ifdef SHARED_ADDER_LOCK_EN
    // requester 1 locks for three back-to-back ops while requester 0 waits
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      req_lock = (i < 2) ? 2'b10 : 2'b00;
      #1;
      chk("lock_grant", {30'd0, req_ready}, 32'd2);
      tick();
    end
    req_lock = 2'b00;
    #1;
    chk("lock_release_grant", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    tick();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/shared_adder_arb.md
# shared_adder_arb

Arbiter and sequencer that time-shares one 32-bit carry-lookahead adder between two requesters inside the multdiv unit: requester 0 is the multiplier partial-product accumulator, requester 1 is the divider remainder update. Each requester issues add/subtract operations over a valid/ready handshake. The block grants one requester per cycle in round-robin order, drives the shared adder, and holds the result in a one-entry output register with backpressure. It replaces two private adders with one.

## Interface
- No parameters; width fixed at 32, requester count fixed at 2.
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- req_valid  in  2  per-requester operation request
- req_ready  out  2  per-requester accept; transfer when valid&ready
- req_a0, req_b0  in  32 each  requester 0 operands
- req_a1, req_b1  in  32 each  requester 1 operands
- req_sub  in  2  per-requester: 1 = a−b, 0 = a+b
- req_lock  in  2  per-requester grant-hold request (used only with SHARED_ADDER_LOCK_EN)
- rsp_valid  out  2  one-hot: result register holds a result for that requester
- rsp_ready  in  2  per-requester result accept
- rsp_data  out  32  registered sum/difference
- rsp_ovf  out  1  registered signed overflow (carry into bit 31 XOR carry out of bit 31)

## Operation
- Adder drive: a = granted req_a; b = req_sub ? ~req_b : req_b; Cin = req_sub. Both result and overflow are captured from the adder outputs.
- Output register state: EMPTY or FULL, with owner id.
  - EMPTY → FULL on accept.
  - FULL → EMPTY on rsp_valid[owner]&rsp_ready[owner] with no new accept.
  - FULL → FULL (new data and owner) on consume plus simultaneous accept.
- Grant eligibility: register EMPTY, or FULL and being consumed this cycle (one-entry pass-through, full throughput).
- Arbitration: a round-robin pointer last_gnt (reset 1, so requester 0 wins first).
  - If both requesters are valid, grant the one that is not last_gnt.
  - If one is valid, grant it.
  - last_gnt updates only on an accepted transfer.
- req_ready[i] = eligible & grant[i]. At most one bit is set. It depends combinationally on req_valid and rsp_ready.
- A requester must hold operands stable while valid&!ready. The arbiter does not latch operands before accept.
- rsp_valid[owner] = FULL; the other bit is 0. rsp_ready of a non-owner is ignored.

## Timing
- Latency: accept in cycle N → rsp_valid, rsp_data, rsp_ovf valid from cycle N+1. They stay stable until consumed.
- Throughput: 1 op/cycle aggregate when the owner's rsp_ready is held high.
- Reset values: req_ready = 0 during reset cycle; rsp_valid = 2'b00, rsp_data = 0, rsp_ovf = 0, state EMPTY, last_gnt = 1, lock cleared.
- Reset mid-operation: a pending result is discarded. The requester must reissue after reset.
- Both requesters valid every cycle: grants strictly alternate 0,1,0,1…
- FULL, owner stalls (rsp_ready low): both req_ready = 0. No grant is made and the pointer is frozen.
- Subtract 0x80000000 − 1: rsp_data 0x7FFFFFFF, rsp_ovf 1.

## Configuration
- SHARED_ADDER_LOCK_EN defined:
  - An accepted transfer with req_lock[i]=1 sets lock owner i.
  - While locked, only requester i is eligible, so multi-step sequences run back-to-back without interleaving.
  - The lock clears on the next accepted transfer from i with req_lock[i]=0, or on reset.
- Not defined: req_lock is ignored, no lock state is built, and pure round-robin applies.

## Structure
- Package shared_adder_pkg:
  - localparam DATA_W = 32
  - typedef enum {REQ_MUL=0, REQ_DIV=1} req_id_t
  - typedef enum {OUT_EMPTY, OUT_FULL} out_state_t
- Sub-module rr_arb2: the 2-way round-robin grant logic, including last_gnt and the optional lock register. Top level holds the operand mux, the adder instance cla_add (ports overflow, s, a, b, Cin), and the output register.

## Test plan
- Reset, then requester 0 only: add 5+7 → req_ready[0] same cycle, rsp_valid=2'b01 next cycle, rsp_data 12, rsp_ovf 0.
- Both valid for 4 cycles, rsp_ready=2'b11 → grants 0,1,0,1; each rsp_valid one cycle after its accept.
- Overflow: 0x7FFFFFFF+1 gives 0x80000000 with ovf 1. Sub 0x80000000−1 gives 0x7FFFFFFF with ovf 1. Sub 3−5 gives 0xFFFFFFFE with ovf 0.
- Backpressure: hold rsp_ready[0]=0 for 3 cycles after a result → req_ready=0, rsp_data stable. Release → consume and next grant happen in the same cycle.
- Reset asserted while FULL → next cycle rsp_valid=0, rsp_data=0, and requester 0 wins the first contended grant.
- With SHARED_ADDER_LOCK_EN: requester 1 issues 3 ops with lock=1,1,0 while requester 0 is valid → requester 1 gets three consecutive grants, then requester 0.
